// File: rtl/clk_int_div_multi_pkg.sv
// -----------------------------------------------------------------------------
// clk_int_div_multi_pkg
//   Shared types and helpers for the multi-channel integer clock divider.
//   - div_state_e  : per-channel reconfiguration FSM states
//   - div_ch_cfg_t : active divider/phase configuration of one channel
//   - div_norm()   : maps a requested division of 0 onto 1
//   - phase_clamp(): drops a start phase that does not fit the division
//   - half_up()    : ceil(div/2), length of the high phase of clk_o
//   Values are carried at DivWidthMax bits internally; channels zero-extend
//   their DivWidth-wide ports into that width.
// -----------------------------------------------------------------------------
package clk_int_div_multi_pkg;

    localparam int unsigned DivWidthMax = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WRAP = 2'd1,
        LOAD      = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [DivWidthMax-1:0] div;
        logic [DivWidthMax-1:0] phase;
    } div_ch_cfg_t;

    // A division of 0 is meaningless; treat it as "divide by 1".
    function automatic logic [DivWidthMax-1:0] div_norm(input logic [DivWidthMax-1:0] div);
        logic [DivWidthMax-1:0] res;
        if (div == {DivWidthMax{1'b0}}) begin
            res = {{(DivWidthMax-1){1'b0}}, 1'b1};
        end else begin
            res = div;
        end
        return res;
    endfunction

    // A start phase outside 0..div-1 would never reach the wrap; use 0 instead.
    function automatic logic [DivWidthMax-1:0] phase_clamp(input logic [DivWidthMax-1:0] phase,
                                                           input logic [DivWidthMax-1:0] div);
        logic [DivWidthMax-1:0] res;
        if (phase < div) begin
            res = phase;
        end else begin
            res = {DivWidthMax{1'b0}};
        end
        return res;
    endfunction

    // ceil(div/2) without the overflow that (div+1)>>1 would have at full scale.
    function automatic logic [DivWidthMax-1:0] half_up(input logic [DivWidthMax-1:0] div);
        return (div >> 1) + {{(DivWidthMax-1){1'b0}}, div[0]};
    endfunction

endpackage

// File: rtl/clk_int_div_multi_channel.sv
// -----------------------------------------------------------------------------
// clk_int_div_channel
//   One divider channel: counter, reconfiguration FSM and registered outputs.
//   Optional feature macro: CLK_INT_DIV_MULTI_GATE_EN -- when defined, tick_o
//   and clk_o are held low for one full new period after every divider load.
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           channel enable (0 holds the counter at 0, outputs low)
//   sync_i         realign: reload counter with the stored phase
//   div_i, phase_i requested division / start phase
//   div_valid_i    reconfiguration request, held until div_ready_o
//   div_ready_o    request accepted this cycle (combinational)
//   tick_o         one-cycle strobe at the end of every period
//   clk_o          divided square wave (registered)
//   cycl_count_o   current counter value
// -----------------------------------------------------------------------------
module clk_int_div_channel
    import clk_int_div_multi_pkg::*;
#(
    parameter int unsigned DivWidth   = 8,
    parameter int unsigned DefaultDiv = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                sync_i,
    input  logic [DivWidth-1:0] div_i,
    input  logic [DivWidth-1:0] phase_i,
    input  logic                div_valid_i,
    output logic                div_ready_o,
    output logic                tick_o,
    output logic                clk_o,
    output logic [DivWidth-1:0] cycl_count_o
);

    localparam logic [DivWidthMax-1:0] DefaultDivW = div_norm(DivWidthMax'(DefaultDiv));

    div_state_e             state_q, state_d;
    div_ch_cfg_t            cfg_q, cfg_d;
    logic [DivWidthMax-1:0] count_q, count_d;
    logic                   tick_q, tick_d;
    logic                   clk_q, clk_d;

    logic [DivWidthMax-1:0] div_in_s;
    logic [DivWidthMax-1:0] phase_in_s;
    logic [DivWidthMax-1:0] div_norm_s;
    logic [DivWidthMax-1:0] phase_clamp_s;
    logic                   wrap_s;
    logic                   load_s;
    logic                   ready_s;
    logic                   mask_s;

    // Widen the request ports into the package working width.
    always_comb begin
        div_in_s                   = {DivWidthMax{1'b0}};
        phase_in_s                 = {DivWidthMax{1'b0}};
        div_in_s[DivWidth-1:0]     = div_i;
        phase_in_s[DivWidth-1:0]   = phase_i;
        div_norm_s                 = div_norm(div_in_s);
        phase_clamp_s              = phase_clamp(phase_in_s, div_norm_s);
        wrap_s                     = (count_q == (cfg_q.div - {{(DivWidthMax-1){1'b0}}, 1'b1}));
    end

    // Reconfiguration FSM: decides when a new division may be loaded.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        ready_s = 1'b0;
        cfg_d   = cfg_q;
        case (state_q)
            IDLE: begin
                if (div_valid_i) begin
                    if (!en_i) begin
                        // Nothing is running, so there is no period to protect.
                        load_s  = 1'b1;
                    end else if (div_norm_s == cfg_q.div) begin
                        // Same division: only the phase changes, counter untouched.
                        ready_s     = 1'b1;
                        cfg_d.phase = phase_clamp_s;
                    end else begin
                        state_d = WAIT_WRAP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_WRAP: begin
                // Load on the last count of the old period, or immediately on a
                // realign pulse; a channel disabled while waiting loads at once
                // so the request cannot stall.
                if (wrap_s || sync_i || !en_i) begin
                    load_s  = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = WAIT_WRAP;
                end
            end
            LOAD: begin
                // One settling cycle so a still-high valid is not taken twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            ready_s     = 1'b1;
            cfg_d.div   = div_norm_s;
            cfg_d.phase = phase_clamp_s;
        end else begin
            cfg_d = cfg_d;
        end
    end

    // Counter next value: disable > load > realign > normal count.
    always_comb begin
        count_d = count_q;
        if (!en_i) begin
            count_d = {DivWidthMax{1'b0}};
        end else if (load_s) begin
            count_d = phase_clamp_s;
        end else if (sync_i) begin
            count_d = cfg_q.phase;
        end else if (wrap_s) begin
            count_d = {DivWidthMax{1'b0}};
        end else begin
            count_d = count_q + {{(DivWidthMax-1){1'b0}}, 1'b1};
        end
    end

`ifdef CLK_INT_DIV_MULTI_GATE_EN
    logic [DivWidthMax-1:0] gate_q, gate_d;

    // Gate countdown: the load cycle plus div-1 further cycles are masked.
    always_comb begin
        gate_d = gate_q;
        if (load_s) begin
            gate_d = div_norm_s - {{(DivWidthMax-1){1'b0}}, 1'b1};
        end else if (gate_q != {DivWidthMax{1'b0}}) begin
            gate_d = gate_q - {{(DivWidthMax-1){1'b0}}, 1'b1};
        end else begin
            gate_d = gate_q;
        end
        mask_s = load_s || (gate_q != {DivWidthMax{1'b0}});
    end

    // Gate countdown register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gate_q <= {DivWidthMax{1'b0}};
        end else begin
            gate_q <= gate_d;
        end
    end
`else
    // No output masking after a load.
    always_comb begin
        mask_s = 1'b0;
    end
`endif

    // Output next values, decoded from the current count and division.
    always_comb begin
        tick_d = en_i && wrap_s && !sync_i;
        clk_d  = en_i && (count_q < half_up(cfg_q.div));
        if (mask_s) begin
            tick_d = 1'b0;
            clk_d  = 1'b0;
        end else begin
            tick_d = tick_d;
            clk_d  = clk_d;
        end
    end

    // State, configuration, counter and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cfg_q   <= '{div: DefaultDivW, phase: {DivWidthMax{1'b0}}};
            count_q <= {DivWidthMax{1'b0}};
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
        end
    end

    // A request seen while reset is asserted is dropped, never acknowledged.
    assign div_ready_o  = ready_s && !rst_i;
    assign tick_o       = tick_q;
    assign clk_o        = clk_q;
    assign cycl_count_o = count_q[DivWidth-1:0];

endmodule

// File: rtl/clk_int_div_multi.sv
// -----------------------------------------------------------------------------
// clk_int_div_multi
//   Multi-channel runtime-configurable integer divider producing clock-enable
//   ticks and divided square waves from a single clk_i.
//   Optional feature macro: CLK_INT_DIV_MULTI_GATE_EN (mask outputs for one
//   new period after every divider load).
// Ports (per channel c, buses packed as [c*DivWidth +: DivWidth])
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i[c]        channel enable
//   sync_i         global realign pulse, fanned out to every channel
//   div_i, phase_i requested division / start phase
//   div_valid_i[c] reconfiguration request; div_ready_o[c] acceptance
//   tick_o[c]      end-of-period strobe; clk_o[c] divided square wave
//   cycl_count_o   current counter values
// -----------------------------------------------------------------------------
module clk_int_div_multi
    import clk_int_div_multi_pkg::*;
#(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned DivWidth    = 8,
    parameter int unsigned DefaultDiv  = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumChannels-1:0]          en_i,
    input  logic                            sync_i,
    input  logic [NumChannels*DivWidth-1:0] div_i,
    input  logic [NumChannels*DivWidth-1:0] phase_i,
    input  logic [NumChannels-1:0]          div_valid_i,
    output logic [NumChannels-1:0]          div_ready_o,
    output logic [NumChannels-1:0]          tick_o,
    output logic [NumChannels-1:0]          clk_o,
    output logic [NumChannels*DivWidth-1:0] cycl_count_o
);

    if (NumChannels < 1) begin : g_bad_channels
        $error("clk_int_div_multi: NumChannels must be at least 1");
    end
    if ((DivWidth < 1) || (DivWidth > DivWidthMax)) begin : g_bad_width
        $error("clk_int_div_multi: DivWidth out of range");
    end
    if (64'(DefaultDiv) > ((64'd1 << DivWidth) - 64'd1)) begin : g_bad_default
        $error("clk_int_div_multi: DefaultDiv not representable in DivWidth bits");
    end

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        clk_int_div_channel #(
            .DivWidth   (DivWidth),
            .DefaultDiv (DefaultDiv)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .en_i         (en_i[g]),
            .sync_i       (sync_i),
            .div_i        (div_i[g*DivWidth +: DivWidth]),
            .phase_i      (phase_i[g*DivWidth +: DivWidth]),
            .div_valid_i  (div_valid_i[g]),
            .div_ready_o  (div_ready_o[g]),
            .tick_o       (tick_o[g]),
            .clk_o        (clk_o[g]),
            .cycl_count_o (cycl_count_o[g*DivWidth +: DivWidth])
        );
    end

endmodule

// File: tb/tb_clk_int_div_multi.sv
// Directed bench for clk_int_div_multi (2 channels, 8-bit, DefaultDiv 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_clk_int_div_multi;

`ifdef CLK_INT_DIV_MULTI_GATE_EN
    localparam bit GateEn = 1'b1;
`else
    localparam bit GateEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  en;
    logic        sync;
    logic [15:0] div;
    logic [15:0] phase;
    logic [1:0]  valid;
    logic [1:0]  ready;
    logic [1:0]  tick;
    logic [1:0]  clko;
    logic [15:0] count;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    clk_int_div_multi #(.NumChannels(2), .DivWidth(8), .DefaultDiv(4)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .sync_i(sync), .div_i(div), .phase_i(phase),
        .div_valid_i(valid), .div_ready_o(ready), .tick_o(tick), .clk_o(clko), .cycl_count_o(count)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 2'b00; sync = 1'b0; valid = 2'b00; div = 16'h0000; phase = 16'h0000;
        step(); step();
        vectors++; if (count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", count); end
        vectors++; if (tick !== 2'b00) begin errors++; $display("FAIL reset_tick: got %b expected 00", tick); end
        vectors++; if (clko !== 2'b00) begin errors++; $display("FAIL reset_clk: got %b expected 00", clko); end
        vectors++; if (ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", ready); end
        rst = 1'b0;
    endtask

    task automatic test_default_div();
        en = 2'b11;
        for (int i = 0; i < 12; i++) begin
            step();
            vectors++;
            if (count !== {2{8'((i + 1) % 4)}} || tick !== {2{(i % 4) == 3}} || clko !== {2{(i % 4) < 2}}) begin
                errors++;
                $display("FAIL div4 cycle %0d: got count=%h tick=%b clk=%b expected count=%0d tick=%0d clk=%0d",
                         i, count, tick, clko, (i + 1) % 4, (i % 4) == 3, (i % 4) < 2);
            end
        end
    endtask

    task automatic test_reconfig();
        bit got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (count[7:0] === 8'd1) got = 1'b1; else step();
        end
        vectors++; if (!got) begin errors++; $display("FAIL reconfig_sync: count 1 not seen, got %0d", count[7:0]); end
        div[7:0] = 8'd5; phase[7:0] = 8'd0; valid[0] = 1'b1;
        #1;
        vectors++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL reconfig_ready_early0: got %b expected 0", ready[0]); end
        step();
        vectors++; if (ready[0] !== 1'b0 || count[7:0] !== 8'd2) begin errors++; $display("FAIL reconfig_ready_early1: got ready=%b count=%0d expected 0/2", ready[0], count[7:0]); end
        step();
        vectors++; if (ready[0] !== 1'b1 || count[7:0] !== 8'd3) begin errors++; $display("FAIL reconfig_ready_wrap: got ready=%b count=%0d expected 1/3", ready[0], count[7:0]); end
        valid[0] = 1'b0;
        step();
        vectors++;
        if (count[7:0] !== 8'd0 || tick[0] !== !GateEn || clko[0] !== 1'b0) begin
            errors++; $display("FAIL reconfig_first: got count=%0d tick=%b clk=%b expected 0/%0d/0", count[7:0], tick[0], clko[0], !GateEn);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            vectors++;
            if (count[7:0] !== 8'((i + 1) % 5) ||
                tick[0] !== ((GateEn && i < 4) ? 1'b0 : ((i % 5) == 4)) ||
                clko[0] !== ((GateEn && i < 4) ? 1'b0 : ((i % 5) < 3))) begin
                errors++;
                $display("FAIL div5 cycle %0d: got count=%0d tick=%b clk=%b", i, count[7:0], tick[0], clko[0]);
            end
        end
    endtask

    task automatic test_equal_div();
        bit got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            if (count[15:8] === 8'd2) got = 1'b1; else step();
        end
        vectors++; if (!got) begin errors++; $display("FAIL equal_sync: count 2 not seen, got %0d", count[15:8]); end
        div[15:8] = 8'd4; phase[15:8] = 8'd2; valid[1] = 1'b1;
        #1;
        vectors++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL equal_ready: got %b expected 1", ready[1]); end
        step();
        valid[1] = 1'b0;
        vectors++; if (count[15:8] !== 8'd3 || tick[1] !== 1'b0) begin errors++; $display("FAIL equal_undisturbed: got count=%0d tick=%b expected 3/0", count[15:8], tick[1]); end
        step();
        vectors++; if (count[15:8] !== 8'd0 || tick[1] !== 1'b1) begin errors++; $display("FAIL equal_tick: got count=%0d tick=%b expected 0/1", count[15:8], tick[1]); end
    endtask

    task automatic test_phase_sync();
        bit got = 1'b0;
        div[7:0] = 8'd4; phase[7:0] = 8'd0; valid[0] = 1'b1;
        for (int k = 0; k < 12 && !got; k++) begin
            #1;
            if (ready[0] === 1'b1) got = 1'b1; else step();
        end
        vectors++; if (!got) begin errors++; $display("FAIL phase_reconfig_timeout: ready got %b expected 1", ready[0]); end
        valid[0] = 1'b0;
        for (int k = 0; k < 6; k++) step();
        for (int rep = 0; rep < 2; rep++) begin
            sync = 1'b1;
            step();
            sync = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) step();
                vectors++;
                if (count[7:0] !== 8'(i % 4) || count[15:8] !== 8'((i + 2) % 4) ||
                    tick[0] !== (i > 0 && (i % 4) == 0) || tick[1] !== ((i % 4) == 2)) begin
                    errors++;
                    $display("FAIL sync rep %0d cycle %0d: got count=%h tick=%b", rep, i, count, tick);
                end
                if (i > 0) begin
                    vectors++;
                    if (clko[0] !== (((i - 1) % 4) < 2) || clko[1] !== (((i + 1) % 4) < 2)) begin
                        errors++; $display("FAIL sync_clk rep %0d cycle %0d: got %b", rep, i, clko);
                    end
                end
            end
        end
    endtask

    task automatic test_div_one();
        bit got = 1'b0;
        bit [5:0] exp_tick;
        bit [5:0] exp_clk;
        div[7:0] = 8'd0; phase[7:0] = 8'd0; valid[0] = 1'b1;
        for (int k = 0; k < 12 && !got; k++) begin
            #1;
            if (ready[0] === 1'b1) got = 1'b1; else step();
        end
        vectors++; if (!got) begin errors++; $display("FAIL div0_timeout: ready got %b expected 1", ready[0]); end
        valid[0] = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (tick[0] !== 1'b1 || clko[0] !== 1'b1 || count[7:0] !== 8'd0) begin
                errors++; $display("FAIL div0 cycle %0d: got tick=%b clk=%b count=%0d expected 1/1/0", i, tick[0], clko[0], count[7:0]);
            end
        end
        div[7:0] = 8'd1; valid[0] = 1'b1;
        #1;
        vectors++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL div1_equal_ready: got %b expected 1", ready[0]); end
        step();
        valid[0] = 1'b0;
        vectors++; if (tick[0] !== 1'b1 || clko[0] !== 1'b1) begin errors++; $display("FAIL div1: got tick=%b clk=%b expected 1/1", tick[0], clko[0]); end
        // div 3 with out-of-range phase 7
        div[7:0] = 8'd3; phase[7:0] = 8'd7; valid[0] = 1'b1;
        #1;
        vectors++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL div3_ready_early: got %b expected 0", ready[0]); end
        step();
        vectors++; if (ready[0] !== 1'b1) begin errors++; $display("FAIL div3_ready: got %b expected 1", ready[0]); end
        valid[0] = 1'b0;
        exp_tick = GateEn ? 6'b001000 : 6'b001001;
        exp_clk  = GateEn ? 6'b110000 : 6'b110111;
        for (int k = 0; k < 6; k++) begin
            step();
            vectors++;
            if (count[7:0] !== 8'(k % 3) || tick[0] !== exp_tick[k] || clko[0] !== exp_clk[k]) begin
                errors++;
                $display("FAIL div3 cycle %0d: got count=%0d tick=%b clk=%b expected %0d/%b/%b",
                         k, count[7:0], tick[0], clko[0], k % 3, exp_tick[k], exp_clk[k]);
            end
        end
        sync = 1'b1;
        step();
        sync = 1'b0;
        vectors++; if (count[7:0] !== 8'd0 || count[15:8] !== 8'd2) begin errors++; $display("FAIL phase_clamp: got count=%h expected 0200", count); end
    endtask

    task automatic test_enable();
        en[1] = 1'b0;
        step();
        vectors++; if (count[15:8] !== 8'd0 || tick[1] !== 1'b0 || clko[1] !== 1'b0) begin errors++; $display("FAIL disabled: got count=%0d tick=%b clk=%b expected 0/0/0", count[15:8], tick[1], clko[1]); end
        div[15:8] = 8'd6; phase[15:8] = 8'd9; valid[1] = 1'b1;
        #1;
        vectors++; if (ready[1] !== 1'b1) begin errors++; $display("FAIL disabled_ready: got %b expected 1", ready[1]); end
        step();
        valid[1] = 1'b0;
        vectors++; if (count[15:8] !== 8'd0 || tick[1] !== 1'b0) begin errors++; $display("FAIL disabled_hold: got count=%0d tick=%b expected 0/0", count[15:8], tick[1]); end
        en[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            vectors++;
            if (count[15:8] !== 8'((i + 1) % 6)) begin errors++; $display("FAIL enable_restart cycle %0d: got %0d expected %0d", i, count[15:8], (i + 1) % 6); end
        end
    endtask

    task automatic test_reset_midreconfig();
        div[7:0] = 8'd7; phase[7:0] = 8'd0; valid[0] = 1'b1;
        step();
        rst = 1'b1;
        #1;
        vectors++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL rst_ready0: got %b expected 0", ready[0]); end
        step();
        vectors++; if (ready[0] !== 1'b0 || count !== 16'h0000) begin errors++; $display("FAIL rst_ready1: got ready=%b count=%h expected 0/0000", ready[0], count); end
        valid[0] = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (count[7:0] !== 8'((i + 1) % 4)) begin errors++; $display("FAIL rst_default cycle %0d: got %0d expected %0d", i, count[7:0], (i + 1) % 4); end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_default_div();
        test_reconfig();
        test_equal_div();
        test_phase_sync();
        test_div_one();
        test_enable();
        test_reset_midreconfig();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
